// File: rtl/montgomery_mult_pkg.sv
// rtl/montgomery_mult_pkg.sv - shared types and constants for the Montgomery multiplier
//
// Holds the FSM state encoding (2 bits), the default operand width and the
// helper that sizes the iteration counter.

package montgomery_mult_pkg;

    localparam int DEFAULT_WIDTH = 1024;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOOP      = 2'd1,
        ST_FINAL_SUB = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Counter must index WIDTH iterations; keep at least one bit for WIDTH=1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mont_iter_step.sv
// rtl/mont_iter_step.sv - one combinational radix-2 Montgomery iteration
//
// Ports:
//   c      in  WIDTH+2  accumulator C (C < 2M)
//   b      in  WIDTH    multiplicand B
//   m      in  WIDTH    odd modulus M
//   a_bit  in  1        current multiplier bit
//   c_next out WIDTH+2  (C + a_bit*B + q*M) / 2, q chosen to make the sum even

module mont_iter_step #(
    parameter int WIDTH = 1024
) (
    input  logic [WIDTH+1:0] c,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    input  logic             a_bit,
    output logic [WIDTH+1:0] c_next
);

    logic [WIDTH+1:0] t_add_b;
    logic [WIDTH+1:0] t_add_m;

    // C < 2M and B < M keep t_add_b < 3M; adding M stays below 4M < 2^(WIDTH+2).
    always_comb begin
        t_add_b = c + {2'b00, b & {WIDTH{a_bit}}};
        t_add_m = t_add_b;
        if (t_add_b[0]) begin
            t_add_m = t_add_b + {2'b00, m};
        end
        // M is odd, so t_add_m is even here and the shift is an exact divide by 2.
        c_next = t_add_m >> 1;
    end

endmodule

// File: rtl/montgomery_mult.sv
// rtl/montgomery_mult.sv - radix-2 bit-serial Montgomery multiplier, a*b*2^-WIDTH mod M
//
// Configuration macro: MONT_FINAL_SUB_EN
//   defined   : FINAL_SUB state present, result < M, done in cycle WIDTH+2
//   undefined : LOOP goes straight to DONE, result < 2M (needs M < 2^(WIDTH-1)),
//               done in cycle WIDTH+1
//
// Ports:
//   clk     in   1      clock
//   resetn  in   1      synchronous active-low reset
//   start   in   1      start pulse, operands sampled in that cycle (IDLE only)
//   in_a    in   WIDTH  multiplier a (a < M)
//   in_b    in   WIDTH  multiplicand b (b < M)
//   in_m    in   WIDTH  odd modulus M
//   result  out  WIDTH  Montgomery product, held until overwritten by the next operation
//   done    out  1      one-cycle pulse, result valid in that cycle

module montgomery_mult
    import montgomery_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH+1:0] c_reg;
    logic [WIDTH+1:0] c_next;

    // a_reg shifts right every iteration, so bit 0 is always a[cnt].
    mont_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .c      (c_reg),
        .b      (b_reg),
        .m      (m_reg),
        .a_bit  (a_reg[0]),
        .c_next (c_next)
    );

`ifdef MONT_FINAL_SUB_EN
    // With M <= C < 2M the difference is below M, so the low WIDTH bits suffice.
    logic [WIDTH-1:0] c_minus_m;
    logic             c_ge_m;

    assign c_minus_m = c_reg[WIDTH-1:0] - m_reg;
    assign c_ge_m    = (c_reg >= {2'b00, m_reg});
`endif

    // done decodes the state register only; start cannot reach it combinationally.
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            m_reg  <= '0;
            c_reg  <= '0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        m_reg <= in_m;
                        c_reg <= '0;
                        cnt   <= '0;
                        state <= ST_LOOP;
                    end
                end

                ST_LOOP: begin
                    c_reg <= c_next;
                    a_reg <= a_reg >> 1;
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
`ifdef MONT_FINAL_SUB_EN
                        state <= ST_FINAL_SUB;
`else
                        // Redundant-range output: C < 2M fits WIDTH bits when M < 2^(WIDTH-1).
                        result <= c_next[WIDTH-1:0];
                        state  <= ST_DONE;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

`ifdef MONT_FINAL_SUB_EN
                ST_FINAL_SUB: begin
                    result <= c_ge_m ? c_minus_m : c_reg[WIDTH-1:0];
                    state  <= ST_DONE;
                end
`endif

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
